// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_core slice.
//   rx_state_t / tx_state_t : FSM state encodings
//   clks_per_bit()          : rounded clk cycles per serial bit
//   UART_MIN_OVERSAMPLE     : smallest allowed clks-per-bit
// Optional build macro: UART_PARITY_EN (adds the RX_PARITY state).
package uart_pkg;

  localparam int UART_MIN_OVERSAMPLE = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Round to nearest so a baud rate that does not divide the clock evenly
  // lands on the closest bit period.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: valid/ready streams between uart_core and its controller.
//   master : controller side (offers TX bytes, pops RX bytes, clears errors)
//   slave  : uart_core side
//   tx_valid/tx_ready/tx_data : TX byte stream
//   rx_valid/rx_ready/rx_data : RX FIFO head stream
//   rx_frame_err/rx_overrun   : sticky error flags, err_clr clears them
// Optional build macro: UART_PARITY_EN (adds sticky rx_parity_err).
interface uart_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 err_clr;
`ifdef UART_PARITY_EN
  logic                 rx_parity_err;
`endif

  modport master (
    output tx_valid, tx_data, rx_ready, err_clr,
    input  tx_ready, rx_valid, rx_data, rx_frame_err,
`ifdef UART_PARITY_EN
    input  rx_parity_err,
`endif
    input  rx_overrun
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready, err_clr,
    output tx_ready, rx_valid, rx_data, rx_frame_err,
`ifdef UART_PARITY_EN
    output rx_parity_err,
`endif
    output rx_overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received words.
//   clk, arst_n : clock, asynchronous active-low reset
//   push, wdata : write request and word (ignored when full unless popping)
//   pop         : read request (ignored when empty)
//   head        : word at the read pointer
//   full, empty : status from pointers with an extra wrap bit
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot the push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with counter-based bit timing and an RX FIFO.
//   clk, arst_n : clock, asynchronous active-low reset (aborts any frame)
//   uart_rx     : serial input, asynchronous to clk
//   uart_tx     : registered serial output, idle high
//   bus         : uart_if slave (TX stream, RX stream, sticky errors, err_clr)
// Optional build macro: UART_PARITY_EN adds parameter PARITY_ODD, a parity
// bit after the data bits, and the sticky bus.rx_parity_err flag.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic  clk,
  input  logic  arst_n,
  input  logic  uart_rx,
  output logic  uart_tx,
  uart_if.slave bus
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int TX_BITS = DATA_BITS + PAR_BITS;

  if (CPB < UART_MIN_OVERSAMPLE || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_core: unsupported CLK_HZ/BAUD, DATA_BITS or STOP_BITS");
  end

  // ---- stage p0/p1: synchroniser, p2: previous value for edge detect ----
  logic rx_sync_p0, rx_sync_p1, rx_prev_p2, rx_fall;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  assign rx_fall = rx_prev_p2 & ~rx_sync_p1;

  // ---- RX frame FSM ----
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 push_req, frame_set, par_set;
  logic                 fifo_full, fifo_empty, pop;
  logic                 frame_err_q, overrun_q, par_err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Half a bit to land in the middle of the start bit.
        if (rx_fall) begin
          rx_cnt_d   = HALF_M1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (rx_sync_p1) rx_state_d = RX_IDLE;
        else begin
          rx_cnt_d   = CPB_M1;
          rx_idx_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_shift_d = {rx_sync_p1, rx_shift_q[DATA_BITS-1:1]};
          rx_cnt_d   = CPB_M1;
          rx_idx_d   = rx_idx_q + 1'b1;
          if (rx_idx_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          par_set    = ((^rx_shift_q) ^ rx_sync_p1) != PARITY_ODD;
          rx_cnt_d   = CPB_M1;
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          frame_set  = ~rx_sync_p1;
          push_req   = rx_sync_p1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---- sticky error flags (clear beats a same-cycle set) ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      frame_err_q <= ~bus.err_clr & (frame_err_q | frame_set);
      overrun_q   <= ~bus.err_clr & (overrun_q | (push_req & fifo_full & ~pop));
      par_err_q   <= ~bus.err_clr & (par_err_q | par_set);
    end
  end

  assign pop              = ~fifo_empty & bus.rx_ready;
  assign bus.rx_valid     = ~fifo_empty;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = par_err_q;
`endif

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push_req),
    .wdata  (rx_shift_q),
    .pop    (pop),
    .head   (bus.rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // ---- TX frame FSM ----
  tx_state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]         tx_idx_q, tx_idx_d;
  logic [TX_BITS-1:0] tx_shift_q, tx_shift_d, tx_word;
  logic               tx_line_q, tx_line_d;

`ifdef UART_PARITY_EN
  assign tx_word = {(^bus.tx_data) ^ PARITY_ODD, bus.tx_data};
`else
  assign tx_word = bus.tx_data;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_shift_d = tx_word;
          tx_line_d  = 1'b0;
          tx_cnt_d   = CPB_M1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else begin
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = '0;
          tx_cnt_d   = CPB_M1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        // tx_idx_q is the index of the bit currently on the line.
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else begin
          tx_cnt_d = CPB_M1;
          if (tx_idx_q == 4'(TX_BITS - 1)) begin
            tx_line_d  = 1'b1;
            tx_idx_d   = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_idx_d   = tx_idx_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else if (tx_idx_q == 4'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
        else begin
          tx_idx_d = tx_idx_q + 1'b1;
          tx_cnt_d = CPB_M1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_tx      = tx_line_q;
  assign bus.tx_ready = (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
module tb_uart_core;
  localparam int CLK_HZ    = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 2;
  localparam int DEPTH     = 4;
  localparam int CPB       = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int FRAME     = (1 + DATA_BITS + STOP_BITS) * CPB;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic tx_pin, rx_pin;

  assign rx_pin = loop_en ? tx_pin : rx_drv;

  uart_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_core #(
    .CLK_HZ        (CLK_HZ),
    .BAUD          (BAUD),
    .DATA_BITS     (DATA_BITS),
    .STOP_BITS     (STOP_BITS),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .uart_rx (rx_pin),
    .uart_tx (tx_pin),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level during serial bit k of a frame carrying b (k=0 is start bit).
  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DATA_BITS) return b[k-1];
    return 1'b1;
  endfunction

  // Offer one byte and check every cycle of the resulting uart_tx waveform.
  task automatic tx_frame(input logic [7:0] b, output int rx_first);
    int n, bad;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", 32'(bus.tx_ready), 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bad = 0;
    rx_first = -1;
    for (int t = 0; t < FRAME; t++) begin
      if (tx_pin !== line_bit(b, t / CPB) || bus.tx_ready !== 1'b0) bad++;
      if (rx_first < 0 && bus.rx_valid === 1'b1) rx_first = t;
      @(negedge clk);
    end
    chk("tx_wave", 32'(bad), 0);
    chk("tx_ready_end", 32'({tx_pin, bus.tx_ready}), 'h3);
  endtask

  // Bit-bang one frame on uart_rx with a single stop bit of the given level.
  task automatic rx_drive(input logic [7:0] b, input logic stop_lvl);
    for (int k = 0; k < DATA_BITS + 2; k++) begin
      rx_drv = (k == DATA_BITS + 1) ? stop_lvl : line_bit(b, k);
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, 32'(bus.rx_valid), 1);
    chk(tag, 32'(bus.rx_data), 32'(exp));
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  logic [7:0] b;
  logic       good, fe_exp, ov_exp;
  logic [7:0] q[$];
  logic [7:0] vb[3];
  int         rx_first, bad, np;
  int         pulse_t[4];

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_ready = 1'b0;
    bus.err_clr  = 1'b0;

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(tx_pin), 1);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data", 32'(bus.rx_data), 0);
    chk("rst_frame_err", 32'(bus.rx_frame_err), 0);
    chk("rst_overrun", 32'(bus.rx_overrun), 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'({tx_pin, bus.tx_ready, bus.rx_valid}), 'h6);

    // Loopback: 0xA5 then a few random bytes
    loop_en = 1'b1;
    tx_frame(8'hA5, rx_first);
    chk("loop_latency_ok", 32'(rx_first >= 9 * CPB && rx_first <= 10 * CPB + CPB / 2), 1);
    pop_chk("loop_a5", 8'hA5);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      tx_frame(b, rx_first);
      pop_chk("loop_rnd", b);
    end
    chk("loop_empty", 32'(bus.rx_valid), 0);

    // Glitch on uart_rx: 3 low cycles are rejected, next frame still received
    loop_en = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_valid", 32'(bus.rx_valid), 0);
    chk("glitch_no_ferr", 32'(bus.rx_frame_err), 0);
    rx_drive(8'h5A, 1'b1);
    repeat (CPB) @(negedge clk);
    pop_chk("after_glitch", 8'h5A);

    // Framing error: word discarded, flag sticky until err_clr
    rx_drive(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_set", 32'(bus.rx_frame_err), 1);
    chk("ferr_no_valid", 32'(bus.rx_valid), 0);
    repeat (5) @(negedge clk);
    chk("ferr_sticky", 32'(bus.rx_frame_err), 1);
    clear_errs();
    chk("ferr_cleared", 32'(bus.rx_frame_err), 0);

    // Overrun: five frames, no pops, FIFO keeps the first DEPTH
    for (int i = 1; i <= 5; i++) rx_drive(8'(i), 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("ovr_set", 32'(bus.rx_overrun), 1);
    chk("ovr_no_ferr", 32'(bus.rx_frame_err), 0);
    for (int i = 1; i <= DEPTH; i++) pop_chk("ovr_data", 8'(i));
    chk("ovr_drained", 32'(bus.rx_valid), 0);
    clear_errs();
    chk("ovr_cleared", 32'(bus.rx_overrun), 0);

    // Random back-to-back RX frames against a queue model
    q.delete();
    fe_exp = 1'b0;
    ov_exp = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(3) != 0);
      rx_drive(b, good);
      if (!good) begin
        fe_exp = 1'b1;
        repeat (CPB) @(negedge clk);
      end else if (q.size() < DEPTH) q.push_back(b);
      else ov_exp = 1'b1;
    end
    repeat (2 * CPB) @(negedge clk);
    chk("rnd_frame_err", 32'(bus.rx_frame_err), 32'(fe_exp));
    chk("rnd_overrun", 32'(bus.rx_overrun), 32'(ov_exp));
    while (q.size() > 0) pop_chk("rnd_data", q.pop_front());
    chk("rnd_drained", 32'(bus.rx_valid), 0);
    clear_errs();

    // TX with tx_valid held: one ready cycle per frame, fixed period
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) vb[i] = 8'($urandom);
    np = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = vb[0];
    for (int c = 0; c < 5 * FRAME && np < 4; c++) begin
      if (bus.tx_ready === 1'b1) begin
        pulse_t[np] = c;
        np++;
        if (np < 4) bus.tx_data = vb[np-1];
        else bus.tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    chk("b2b_pulses", 32'(np), 4);
    for (int k = 0; k < 3; k++)
      if (k + 1 < np) chk("b2b_period", 32'(pulse_t[k+1] - pulse_t[k]), 32'(FRAME + 1));
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) pop_chk("b2b_loop", vb[i]);

    // Reset in the middle of data bit 3
    loop_en = 1'b0;
    b = 8'($urandom) & 8'hF7;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("midtx_bit3_low", 32'({tx_pin, bus.tx_ready}), 0);
    arst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx_pin), 1);
    chk("rst_async_ready", 32'(bus.tx_ready), 1);
    @(negedge clk);
    arst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1 || bus.tx_ready !== 1'b1) bad++;
    end
    chk("no_resume", 32'(bad), 0);
    chk("rst_rx_empty", 32'(bus.rx_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
